// File: rtl/password_programmer.sv
// -----------------------------------------------------------------------------
// password_programmer
//
// Lets an authorized user replace the stored 4-digit password. The new code is
// entered once (ENTER) and then re-entered for confirmation (CONFIRM). A full
// match commits it (COMMIT). A mismatch, an invalid digit or a timeout aborts
// the attempt (FAIL).
//
// Optional feature: define PWPROG_TIMEOUT_EN to abort an entry that sits idle
// for TIMEOUT_CYCLES cycles. Without the macro, entry waits indefinitely.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_authorized   level from code checker, sampled only when start is accepted
//   i_start        one-cycle request to begin a code change
//   i_pb_pulse     one-cycle debounced confirm pulse for the current digit
//   i_digit        digit on the switches (valid 0-9)
//   o_stored_code  active password, nibble [15:12] is the first digit
//   o_stage        0 IDLE, 1 ENTER, 2 CONFIRM, 3 COMMIT, 4 FAIL
//   o_digit_idx    index of the next digit expected in ENTER/CONFIRM
//   o_disp0..3     echo nibbles for 7-segment decoders, 4'hF = blank
//   o_done         one-cycle pulse when a new code is committed
//   o_err          one-cycle pulse when an attempt is aborted
// -----------------------------------------------------------------------------
module password_programmer #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned TIMEOUT_CYCLES = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_authorized,
  input  logic        i_start,
  input  logic        i_pb_pulse,
  input  logic [3:0]  i_digit,
  output logic [15:0] o_stored_code,
  output logic [2:0]  o_stage,
  output logic [1:0]  o_digit_idx,
  output logic [3:0]  o_disp0,
  output logic [3:0]  o_disp1,
  output logic [3:0]  o_disp2,
  output logic [3:0]  o_disp3,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEnter   = 3'd1,
    StConfirm = 3'd2,
    StCommit  = 3'd3,
    StFail    = 3'd4
  } state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_idx, w_idx_d;
  logic [15:0] r_scratch, w_scratch_d;
  logic [15:0] r_stored, w_stored_d;
  logic        r_done, w_done_d;
  logic        r_err, w_err_d;
  logic [3:0]  r_disp [4];
  logic [3:0]  w_disp_d [4];

  logic        w_digit_ok;
  logic [3:0]  w_cur_nib;
  logic        w_in_entry;
  logic        w_timeout;

  assign w_digit_ok = (i_digit <= 4'd9);
  assign w_in_entry = (r_state == StEnter) || (r_state == StConfirm);

  // Scratch nibble addressed by the current digit index (idx 0 -> [15:12]).
  always_comb begin
    w_cur_nib = r_scratch[15:12];
    unique case (r_idx)
      2'd0: w_cur_nib = r_scratch[15:12];
      2'd1: w_cur_nib = r_scratch[11:8];
      2'd2: w_cur_nib = r_scratch[7:4];
      2'd3: w_cur_nib = r_scratch[3:0];
      default: w_cur_nib = r_scratch[15:12];
    endcase
  end

`ifdef PWPROG_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_cnt, w_cnt_d;

  // Expiry wins over a pb_pulse arriving in the same cycle.
  assign w_timeout = w_in_entry && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_cnt_d = '0;
    if (w_in_entry && !w_timeout) begin
      w_cnt_d = i_pb_pulse ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_idx     <= 2'd0;
      r_scratch <= 16'h0000;
      r_stored  <= DEFAULT_CODE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int n = 0; n < 4; n++) r_disp[n] <= 4'hF;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_scratch <= w_scratch_d;
      r_stored  <= w_stored_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      for (int n = 0; n < 4; n++) r_disp[n] <= w_disp_d[n];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_scratch_d = r_scratch;
    w_stored_d  = r_stored;
    unique case (r_state)
      StIdle: begin
        // pb_pulse in IDLE (including alongside start) is discarded.
        if (i_start && i_authorized) begin
          w_state_d   = StEnter;
          w_idx_d     = 2'd0;
          w_scratch_d = 16'h0000;
        end
      end
      StEnter: begin
        if (w_timeout) begin
          w_state_d = StFail;
          w_idx_d   = 2'd0;
        end else if (i_pb_pulse) begin
          if (!w_digit_ok) begin
            w_state_d = StFail;
            w_idx_d   = 2'd0;
          end else begin
            unique case (r_idx)
              2'd0: w_scratch_d[15:12] = i_digit;
              2'd1: w_scratch_d[11:8]  = i_digit;
              2'd2: w_scratch_d[7:4]   = i_digit;
              2'd3: w_scratch_d[3:0]   = i_digit;
              default: w_scratch_d = r_scratch;
            endcase
            if (r_idx == 2'd3) begin
              w_state_d = StConfirm;
              w_idx_d   = 2'd0;
            end else begin
              w_idx_d = r_idx + 2'd1;
            end
          end
        end
      end
      StConfirm: begin
        if (w_timeout) begin
          w_state_d = StFail;
          w_idx_d   = 2'd0;
        end else if (i_pb_pulse) begin
          if (!w_digit_ok || (i_digit != w_cur_nib)) begin
            w_state_d = StFail;
            w_idx_d   = 2'd0;
          end else if (r_idx == 2'd3) begin
            w_state_d = StCommit;
            w_idx_d   = 2'd0;
          end else begin
            w_idx_d = r_idx + 2'd1;
          end
        end
      end
      StCommit: begin
        w_stored_d = r_scratch;
        w_state_d  = StIdle;
      end
      StFail: begin
        w_scratch_d = 16'h0000;
        w_state_d   = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_idx_d   = 2'd0;
      end
    endcase
  end

  // Output logic: computed from next state so every output is a register.
  always_comb begin
    w_done_d = (w_state_d == StCommit);
    w_err_d  = (w_state_d == StFail);
    for (int n = 0; n < 4; n++) begin
      w_disp_d[n] = 4'hF;
      if (((w_state_d == StEnter) || (w_state_d == StConfirm)) && (n < int'(w_idx_d))) begin
        w_disp_d[n] = w_scratch_d[15-4*n -: 4];
      end
    end
  end

  assign o_stored_code = r_stored;
  assign o_stage       = r_state;
  assign o_digit_idx   = r_idx;
  assign o_disp0       = r_disp[0];
  assign o_disp1       = r_disp[1];
  assign o_disp2       = r_disp[2];
  assign o_disp3       = r_disp[3];
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_password_programmer.sv
// Directed bench for password_programmer. Inputs change on the falling edge;
// outputs are compared on the falling edge after the rising edge of interest.
module tb_password_programmer;

  logic        clk;
  logic        rst;
  logic        authorized;
  logic        start;
  logic        pb_pulse;
  logic [3:0]  digit;
  logic [15:0] stored_code;
  logic [2:0]  stage;
  logic [1:0]  digit_idx;
  logic [3:0]  disp0, disp1, disp2, disp3;
  logic        done;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  password_programmer #(
    .DEFAULT_CODE   (16'h1234),
    .TIMEOUT_CYCLES (12)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_authorized  (authorized),
    .i_start       (start),
    .i_pb_pulse    (pb_pulse),
    .i_digit       (digit),
    .o_stored_code (stored_code),
    .o_stage       (stage),
    .o_digit_idx   (digit_idx),
    .o_disp0       (disp0),
    .o_disp1       (disp1),
    .o_disp2       (disp2),
    .o_disp3       (disp3),
    .o_done        (done),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: hold inputs for one rising edge, return at the
  // next falling edge with inputs idle.
  task automatic drive(input logic s, input logic a, input logic p, input logic [3:0] d);
    start      = s;
    authorized = a;
    pb_pulse   = p;
    digit      = d;
    @(negedge clk);
    start      = 1'b0;
    pb_pulse   = 1'b0;
    digit      = 4'h0;
  endtask

  task automatic pb(input logic [3:0] d);
    drive(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] disp_word();
    return {disp3, disp2, disp1, disp0};
  endfunction

  initial begin
    rst = 1'b1; authorized = 1'b0; start = 1'b0; pb_pulse = 1'b0; digit = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_code", 32'(stored_code), 32'h1234);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_disp", 32'(disp_word()), 32'hFFFF);

    // Successful change to 5678
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    check("t1_enter", 32'(stage), 32'd1);
    check("t1_idx0", 32'(digit_idx), 32'd0);
    pb(4'd5); pb(4'd6);
    check("t1_disp2", 32'(disp_word()), 32'hFF65);
    pb(4'd7); pb(4'd8);
    check("t1_confirm", 32'(stage), 32'd2);
    check("t1_cidx", 32'(digit_idx), 32'd0);
    check("t1_cdisp", 32'(disp_word()), 32'hFFFF);
    pb(4'd5); pb(4'd6); pb(4'd7);
    check("t1_cidx3", 32'(digit_idx), 32'd3);
    check("t1_cdisp3", 32'(disp_word()), 32'hF765);
    pb(4'd8);
    check("t1_commit", 32'(stage), 32'd3);
    check("t1_done", 32'({done, err}), 32'b10);
    check("t1_code_old", 32'(stored_code), 32'h1234);
    @(negedge clk);
    check("t1_idle", 32'(stage), 32'd0);
    check("t1_done_low", 32'(done), 32'd0);
    check("t1_code_new", 32'(stored_code), 32'h5678);

    // Reset mid-entry after 6 valid pulses
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    pb(4'd1); pb(4'd2); pb(4'd3); pb(4'd4); pb(4'd1); pb(4'd2);
    check("t6_pre_stage", 32'(stage), 32'd2);
    check("t6_pre_idx", 32'(digit_idx), 32'd2);
    do_reset();
    check("t6_stage", 32'(stage), 32'd0);
    check("t6_idx", 32'(digit_idx), 32'd0);
    check("t6_code", 32'(stored_code), 32'h1234);
    check("t6_done_err", 32'({done, err}), 32'd0);
    check("t6_disp", 32'(disp_word()), 32'hFFFF);

    // Unauthorized start is ignored
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    check("t2_stage", 32'(stage), 32'd0);
    check("t2_done_err", 32'({done, err}), 32'd0);
    check("t2_code", 32'(stored_code), 32'h1234);

    // start with pb together: pb discarded; then confirm mismatch
    drive(1'b1, 1'b1, 1'b1, 4'd7);
    check("t3_enter", 32'(stage), 32'd1);
    check("t3_idx", 32'(digit_idx), 32'd0);
    pb(4'd5); pb(4'd6); pb(4'd7); pb(4'd8);
    pb(4'd5); pb(4'd6); pb(4'd9);
    check("t3_fail", 32'(stage), 32'd4);
    check("t3_err", 32'({done, err}), 32'b01);
    check("t3_fail_disp", 32'(disp_word()), 32'hFFFF);
    @(negedge clk);
    check("t3_idle", 32'(stage), 32'd0);
    check("t3_err_low", 32'(err), 32'd0);
    check("t3_code", 32'(stored_code), 32'h1234);

    // Echo, start ignored mid-entry, invalid digit
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    pb(4'd3); pb(4'd4);
    check("t4_disp", 32'(disp_word()), 32'hFF43);
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    check("t4_restart_idx", 32'(digit_idx), 32'd2);
    check("t4_restart_stage", 32'(stage), 32'd1);
    pb(4'hB);
    check("t4_fail", 32'(stage), 32'd4);
    check("t4_err", 32'({done, err}), 32'b01);
    @(negedge clk);
    check("t4_idle", 32'(stage), 32'd0);

    // Idle during entry
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    pb(4'd2);
`ifdef PWPROG_TIMEOUT_EN
    repeat (11) @(negedge clk);
    check("t5_pre_expiry", 32'(stage), 32'd1);
    @(negedge clk);
    check("t5_timeout_stage", 32'(stage), 32'd4);
    check("t5_timeout_err", 32'(err), 32'd1);
    @(negedge clk);
    check("t5_idle", 32'(stage), 32'd0);
`else
    repeat (100) @(negedge clk);
    check("t5_wait_stage", 32'(stage), 32'd1);
    check("t5_wait_err", 32'(err), 32'd0);
    check("t5_wait_idx", 32'(digit_idx), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/password_programmer.md
PASSWORD_PROGRAMMER -- requirements
Module: password_programmer

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h1234, code loaded into stored_code on reset (nibble [15:12] = first digit).
REQ-002 Parameter TIMEOUT_CYCLES, 12, idle cycles tolerated during entry before abort (used only with PWPROG_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 authorized  input  1  level from the code checker; high = user currently admitted.
REQ-006 start  input  1  one-cycle pulse requesting a code change.
REQ-007 pb_pulse  input  1  one-cycle debounced confirm pulse from the entry button.
REQ-008 digit  input  4  digit on the switches, valid 0-9.
REQ-009 stored_code  output  16  active password, consumed by the checker.
REQ-010 stage  output  3  0 IDLE, 1 ENTER, 2 CONFIRM, 3 COMMIT, 4 FAIL.
REQ-011 digit_idx  output  2  index of next digit expected in ENTER/CONFIRM.
REQ-012 disp0..disp3  output  4 each  echo values for external 7-segment decoders; 4'hF = blank.
REQ-013 done  output  1  one-cycle pulse when new code committed.
REQ-014 err  output  1  one-cycle pulse when a change attempt is aborted.

Function
REQ-015 IDLE: start accepted only when authorized=1 in the same cycle -> ENTER, digit_idx=0, scratch code cleared; start otherwise ignored.
REQ-016 start while not IDLE SHALL be ignored; authorized is sampled only at start acceptance.
REQ-017 start and pb_pulse together in IDLE: start accepted, pb_pulse discarded.
REQ-018 ENTER: on pb_pulse with digit<=9, write digit into scratch nibble digit_idx (idx 0 -> [15:12]), increment digit_idx; after 4th digit -> CONFIRM, digit_idx=0.
REQ-019 ENTER or CONFIRM: pb_pulse with digit>9 -> FAIL.
REQ-020 CONFIRM: on pb_pulse, digit equal to scratch nibble digit_idx -> increment; mismatch -> FAIL; 4th match -> COMMIT.
REQ-021 COMMIT: lasts exactly one cycle; stored_code <= scratch, done=1, next state IDLE.
REQ-022 FAIL: lasts exactly one cycle; err=1, stored_code unchanged, scratch cleared, next state IDLE.
REQ-023 Latency: done asserts in the cycle after the clock edge that registers the 8th valid pb_pulse; stored_code shows new value the following cycle.
REQ-024 done and err never asserted together; each high for exactly one cycle per attempt.
REQ-025 Echo: in ENTER dispN = scratch nibble N for N<digit_idx, else 4'hF; in CONFIRM same rule applied to confirmed digits; in IDLE/COMMIT/FAIL all 4'hF.
REQ-026 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 at a clock edge: stage=IDLE, digit_idx=0, stored_code=DEFAULT_CODE, scratch=0, done=0, err=0, disp0..3=4'hF, timeout counter=0.
REQ-028 rst mid-entry SHALL abort without err pulse; stored_code reverts to DEFAULT_CODE.

Configuration
REQ-029 Macro PWPROG_TIMEOUT_EN defined: cycle counter clears on entry into ENTER and on every accepted pb_pulse, counts every other ENTER/CONFIRM cycle; reaching TIMEOUT_CYCLES -> FAIL; pb_pulse in the expiry cycle is ignored.
REQ-030 Macro undefined: no counter logic; ENTER/CONFIRM wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-031 authorized=1, start, digits 5,6,7,8 then 5,6,7,8 -> done one cycle, stored_code=16'h5678, stage returns 0.
REQ-032 authorized=0, start -> stage stays 0, no done/err, stored_code=16'h1234.
REQ-033 Enter 5,6,7,8, confirm 5,6,9 -> err one cycle after 3rd confirm pulse, stored_code unchanged 16'h1234.
REQ-034 In ENTER, digit=4'hB with pb_pulse -> err, stage 0; in ENTER after 2 digits (3,4) disp0=3, disp1=4, disp2=disp3=4'hF.
REQ-035 PWPROG_TIMEOUT_EN, after start and one digit, 12 idle cycles -> err, stage 0; without macro, 100 idle cycles -> still stage 1.
REQ-036 rst asserted after 6 valid pulses -> all outputs at reset values, stored_code=16'h1234, no err.
